fmap_frame_relay: RTL
=====================

Name: fmap_frame_relay

Overview:
- Sits between two VGG16 conv layers and acts as the receiving end of one layer's valid-strobed pixel stream and the transmitting end for the next.
- Captures one full WIDTH x WIDTH feature map, one pixel of CHANNELS x DATA_WIDTH per beat, into an on-chip frame buffer.
- Once the frame is complete, replays it in raster order as a contiguous valid-strobed burst.
- Replaces the file-based hand-off between layer benches with in-fabric buffering.

Parameters:
- DATA_WIDTH, 32, bits per channel value.
- CHANNELS, 32, channels packed per pixel beat.
- WIDTH, 14, feature-map side length. DIM = WIDTH*WIDTH beats per frame.
- GAP, 0, idle cycles inserted between end of capture and start of replay.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous, active-high.
- s_data, input, DATA_WIDTH*CHANNELS, incoming pixel from the producing layer.
- s_valid, input, 1, s_data valid this cycle. No backpressure.
- m_data, output, DATA_WIDTH*CHANNELS, replayed pixel to the consuming layer.
- m_valid, output, 1, m_data valid this cycle.
- busy, output, 1, high in WAIT or DRAIN state.
- frame_done, output, 1, one-cycle pulse coincident with the last replay beat.
- overflow, output, 1, sticky: input beat dropped because the buffer was not in FILL.
- frame_cnt, output, 8, count of completed replays, wraps 255->0.

Behaviour:
- Reset (async assert): state=FILL; waddr=raddr=gap_cnt=0. Outputs m_valid, frame_done, busy, overflow = 0; m_data = 0; frame_cnt = 0. Buffer contents are don't-care.
- Reset mid-operation aborts the frame; after deassertion the next s_valid beat is written to address 0.
- Memory: DIM x (DATA_WIDTH*CHANNELS), one synchronous write port and one synchronous read port.
- FILL state:
  - Each edge with s_valid=1 writes mem[waddr]<=s_data and increments waddr.
  - Gaps in s_valid are allowed; waddr holds during gaps.
  - On the edge writing waddr=DIM-1: waddr<=0, and state<=WAIT (GAP>0, gap_cnt<=GAP-1) or state<=DRAIN (GAP=0).
- WAIT state: decrement gap_cnt each edge; when gap_cnt=0, state<=DRAIN on that edge.
- DRAIN state:
  - Every edge: m_data<=mem[raddr], m_valid<=1, raddr<=raddr+1.
  - On the edge reading raddr=DIM-1: raddr<=0, frame_done<=1, frame_cnt<=frame_cnt+1, state<=FILL.
- In all other cycles m_valid<=0 and frame_done<=0. m_data holds its last value while m_valid=0 and is checked only when valid.
- Latency, GAP=0: last input beat sampled at edge E0; first m_valid high after edge E0+1. Then DIM consecutive beats; last beat after edge E0+DIM, with frame_done high in the same cycle.
- Latency, general: first replay beat appears GAP+1 edges after the last capture edge.
- busy is combinational from state: high in WAIT or DRAIN.
- Input during WAIT/DRAIN: s_valid=1 is dropped, no write occurs, overflow<=1. overflow clears only on rst.
- Because of the drop rule, a write and a read never target the buffer in the same state; no read/write collision handling is needed.
- s_valid=1 in the cycle right after DRAIN->FILL is accepted and written to address 0. Back-to-back frames therefore work when the producer leaves at least DIM+GAP idle cycles between frames.
- frame_cnt increments once per completed replay, 8-bit wrap.

Test Plan:
- Capture/replay identity, GAP=0: rst 1 for 10ns, then 196 contiguous beats with s_data = index (pixel k, all channels = k). Expect the first m_valid one cycle after the last input, 196 consecutive m_valid beats with m_data channel0 = 0..195 in order, frame_done high only on beat 195, frame_cnt=1, overflow=0.
- Gapped input: same 196 pixels with s_valid toggling 1,0,1,0. Expect identical replay order and values, replay starting one cycle after pixel 195.
- GAP=5: contiguous frame. Expect busy rising the cycle after the last write, 5 idle cycles, then the first m_valid 6 edges after the last capture edge.
- Overflow: drive 3 extra s_valid beats during DRAIN. Expect overflow=1 held through a subsequent full frame, replayed data unchanged (0..195), and 196 beats total.
- Reset mid-operation: assert rst after 100 input beats. Expect m_valid=0, busy=0, frame_cnt=0 immediately; a fresh 196-beat frame after release replays from its own pixel 0.
- Back-to-back frames: two frames (values 0..195, then 1000..1195) separated by 200 idle cycles. Expect two replays with correct values, frame_cnt=2, two frame_done pulses.

Source files
------------

// File: rtl/fmap_frame_relay.sv
// rtl/fmap_frame_relay.sv - captures one feature map from a valid-strobed stream and replays it as a burst
module fmap_frame_relay #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 32,
  parameter int WIDTH      = 14,
  parameter int GAP        = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*CHANNELS-1:0] s_data,
  input  logic                           s_valid,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_data,
  output logic                           m_valid,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overflow,
  output logic [7:0]                     frame_cnt
);

  localparam int DIM = WIDTH * WIDTH;
  localparam int PW  = DATA_WIDTH * CHANNELS;
  localparam int AW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] mem [DIM];

  // Writes are gated to FILL, so the read port never sees a same-cycle write.
  always_ff @(posedge clk) begin
    if (state == ST_FILL && s_valid) begin
      mem[waddr] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FILL;
      waddr      <= '0;
      raddr      <= '0;
      gap_cnt    <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      m_valid    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_FILL: begin
          if (s_valid) begin
            if (waddr == AW'(DIM - 1)) begin
              waddr <= '0;
              if (GAP > 0) begin
                gap_cnt <= GW'(GAP - 1);
                state   <= ST_WAIT;
              end else begin
                state   <= ST_DRAIN;
              end
            end else begin
              waddr <= waddr + AW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (s_valid) overflow <= 1'b1;
          if (gap_cnt == '0) begin
            state <= ST_DRAIN;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        ST_DRAIN: begin
          if (s_valid) overflow <= 1'b1;
          m_data  <= mem[raddr];
          m_valid <= 1'b1;
          if (raddr == AW'(DIM - 1)) begin
            raddr      <= '0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            state      <= ST_FILL;
          end else begin
            raddr <= raddr + AW'(1);
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign busy = (state == ST_WAIT) || (state == ST_DRAIN);

endmodule
